// File: rtl/host_rd_arb.sv
// Round-robin arbiter sharing one in-order Avalon-MM host read channel among NUM_REQ read engines.
// Optional per-requester accept counters are built when HOST_RD_ARB_PERF_EN is defined.
module host_rd_arb #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 48,
    parameter int DATA_W          = 512,
    parameter int BURST_W         = 7,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         src_read,
    input  logic [NUM_REQ*ADDR_W-1:0]  src_address,
    input  logic [NUM_REQ*BURST_W-1:0] src_burstcount,
    output logic [NUM_REQ-1:0]         src_waitrequest,
    output logic [DATA_W-1:0]          src_readdata,
    output logic [NUM_REQ-1:0]         src_readdatavalid,
    output logic                       snk_read,
    output logic [ADDR_W-1:0]          snk_address,
    output logic [BURST_W-1:0]         snk_burstcount,
    input  logic                       snk_waitrequest,
    input  logic [DATA_W-1:0]          snk_readdata,
    input  logic                       snk_readdatavalid,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                       rsp_err,
    output logic [NUM_REQ*32-1:0]      perf_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0]   last_gnt;
    logic [IDX_W-1:0]   sel;
    int                 idx;
    logic               found;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic [BURST_W-1:0] sel_bc;
    logic [BURST_W-1:0] push_bc;

    logic [IDX_W-1:0]   fifo_id [MAX_OUTSTANDING];
    logic [BURST_W-1:0] fifo_bc [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [IDX_W-1:0]   head_id;
    logic [BURST_W-1:0] head_bc;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W:0]   beat_next;
    logic               rsp_valid;
    logic               pop;

    // Round-robin scan starting one past the last granted requester.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_gnt) + k) % NUM_REQ;
            if (!found && src_read[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign fifo_full      = (outstanding == FULL_LVL);
    assign fifo_empty     = (outstanding == '0);
    assign snk_read       = (|src_read) & ~fifo_full;
    assign snk_address    = src_address[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_bc         = src_burstcount[int'(sel)*BURST_W +: BURST_W];
    assign snk_burstcount = sel_bc;
    assign accept         = snk_read & ~snk_waitrequest;
    // A zero burstcount is illegal; route it as a single beat so the FIFO never waits forever.
    assign push_bc        = (sel_bc == '0) ? BURST_W'(1) : sel_bc;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            src_waitrequest[i] = ~(accept && (sel == IDX_W'(i)));
        end
    end

    assign head_id           = fifo_id[rd_ptr];
    assign head_bc           = fifo_bc[rd_ptr];
    assign rsp_valid         = snk_readdatavalid & ~fifo_empty;
    assign beat_next         = {1'b0, beat_cnt} + 1'b1;
    assign pop               = rsp_valid && (beat_next == {1'b0, head_bc});
    assign src_readdata      = snk_readdata;
    assign src_readdatavalid = rsp_valid ? (NUM_REQ'(1) << head_id) : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_id[wr_ptr] <= sel;
            fifo_bc[wr_ptr] <= push_bc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt    <= IDX_W'(NUM_REQ - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            rsp_err     <= 1'b0;
        end else begin
            if (accept) begin
                last_gnt <= sel;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= '0;
            end else if (rsp_valid) begin
                beat_cnt <= beat_next[BURST_W-1:0];
            end
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            // Beats with no burst in flight are orphans from a reset or a misbehaving host.
            if (snk_readdatavalid && fifo_empty) begin
                rsp_err <= 1'b1;
            end
        end
    end

`ifdef HOST_RD_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && (sel == IDX_W'(i))) begin
                    perf_cnt[i*32 +: 32] <= perf_cnt[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_host_rd_arb.sv
// Directed self-checking bench for host_rd_arb: grant order, stalls, full FIFO,
// response steering, orphan-beat error, reset mid-flight and perf counters.
module tb_host_rd_arb;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 48;
   localparam int DATA_W  = 512;
   localparam int BURST_W = 7;
   localparam int MAX_OUT = 16;

   logic                       clk;
   logic                       reset;
   logic [NUM_REQ-1:0]         src_read;
   logic [NUM_REQ*ADDR_W-1:0]  src_address;
   logic [NUM_REQ*BURST_W-1:0] src_burstcount;
   logic [NUM_REQ-1:0]         src_waitrequest;
   logic [DATA_W-1:0]          src_readdata;
   logic [NUM_REQ-1:0]         src_readdatavalid;
   logic                       snk_read;
   logic [ADDR_W-1:0]          snk_address;
   logic [BURST_W-1:0]         snk_burstcount;
   logic                       snk_waitrequest;
   logic [DATA_W-1:0]          snk_readdata;
   logic                       snk_readdatavalid;
   logic [$clog2(MAX_OUT):0]   outstanding;
   logic                       rsp_err;
   logic [NUM_REQ*32-1:0]      perf_cnt;

   int passCount  = 0;
   int checkCount = 0;

   logic [63:0] expPerf;
   logic [1:0]  expOwner [4];

   host_rd_arb #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .BURST_W(BURST_W), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk), .reset(reset),
      .src_read(src_read), .src_address(src_address), .src_burstcount(src_burstcount),
      .src_waitrequest(src_waitrequest), .src_readdata(src_readdata),
      .src_readdatavalid(src_readdatavalid),
      .snk_read(snk_read), .snk_address(snk_address), .snk_burstcount(snk_burstcount),
      .snk_waitrequest(snk_waitrequest), .snk_readdata(snk_readdata),
      .snk_readdatavalid(snk_readdatavalid),
      .outstanding(outstanding), .rsp_err(rsp_err), .perf_cnt(perf_cnt)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Advance one clock, then drive a new input vector 1 ns after the edge
   task automatic applyStimulus(input logic [1:0] rd, input logic [6:0] bc0, input logic [6:0] bc1,
                                input logic wr, input logic rdv, input logic [63:0] data);
      @(posedge clk);
      #1;
      src_read          = rd;
      src_burstcount    = {bc1, bc0};
      snk_waitrequest   = wr;
      snk_readdatavalid = rdv;
      snk_readdata      = DATA_W'(data);
      #1;
   endtask

   // Assert reset asynchronously between edges and release it after the next edge
   task automatic pulseReset();
      @(posedge clk);
      #1;
      src_read          = '0;
      snk_readdatavalid = 1'b0;
      snk_waitrequest   = 1'b0;
      reset             = 1'b1;
      #1;
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   // Main directed sequence
   initial begin
      reset             = 1'b1;
      src_read          = '0;
      src_address       = '0;
      src_burstcount    = '0;
      snk_waitrequest   = 1'b0;
      snk_readdata      = '0;
      snk_readdatavalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_waitreq", 64'(src_waitrequest), 64'h3);
      checkOutput("rst_snk_read", 64'(snk_read), 64'h0);
      checkOutput("rst_rdv", 64'(src_readdatavalid), 64'h0);
      checkOutput("rst_outstanding", 64'(outstanding), 64'h0);
      checkOutput("rst_err", 64'(rsp_err), 64'h0);
      checkOutput("rst_perf", 64'(perf_cnt), 64'h0);
      releaseReset();

      // Single burst of 4 from requester 0
      src_address = {48'h3000, 48'h1000};
      applyStimulus(2'b01, 7'd4, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t1_snk_read", 64'(snk_read), 64'h1);
      checkOutput("t1_addr", 64'(snk_address), 64'h1000);
      checkOutput("t1_bc", 64'(snk_burstcount), 64'h4);
      checkOutput("t1_waitreq", 64'(src_waitrequest), 64'h2);
      applyStimulus(2'b00, 7'd4, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t1_out_after_accept", 64'(outstanding), 64'h1);
      for (int b = 0; b < 4; b++) begin
         applyStimulus(2'b00, 7'd4, 7'd1, 1'b0, 1'b1, 64'hA0 + 64'(b));
         checkOutput("t1_rdv", 64'(src_readdatavalid), 64'h1);
         checkOutput("t1_data", src_readdata[63:0], 64'hA0 + 64'(b));
         checkOutput("t1_out_mid", 64'(outstanding), 64'h1);
      end
      applyStimulus(2'b00, 7'd4, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t1_out_drained", 64'(outstanding), 64'h0);

      // Both requesters continuously; last grant was 0 so order is 1,0,1,0
      src_address = {48'h3000, 48'h2000};
      expOwner[0] = 2'd1; expOwner[1] = 2'd0; expOwner[2] = 2'd1; expOwner[3] = 2'd0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b11, 7'd1, 7'd1, 1'b0, 1'b0, 64'h0);
         checkOutput("t2_waitreq", 64'(src_waitrequest), (expOwner[k] == 2'd1) ? 64'h1 : 64'h2);
         checkOutput("t2_addr", 64'(snk_address), (expOwner[k] == 2'd1) ? 64'h3000 : 64'h2000);
      end
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t2_out", 64'(outstanding), 64'h4);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b1, 64'h0);
         checkOutput("t2_rdv", 64'(src_readdatavalid), (expOwner[k] == 2'd1) ? 64'h2 : 64'h1);
      end
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t2_out_drained", 64'(outstanding), 64'h0);

      // Requester 1 stalled by sink for 3 cycles, accepted on the 4th
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'b10, 7'd1, 7'd2, 1'b1, 1'b0, 64'h0);
         checkOutput("t3_stall_waitreq", 64'(src_waitrequest), 64'h3);
         checkOutput("t3_stall_snk_read", 64'(snk_read), 64'h1);
      end
      applyStimulus(2'b10, 7'd1, 7'd2, 1'b0, 1'b0, 64'h0);
      checkOutput("t3_accept_waitreq", 64'(src_waitrequest), 64'h1);
      checkOutput("t3_out_before", 64'(outstanding), 64'h0);
      applyStimulus(2'b00, 7'd1, 7'd2, 1'b0, 1'b1, 64'h0);
      checkOutput("t3_out_after", 64'(outstanding), 64'h1);
      checkOutput("t3_rdv0", 64'(src_readdatavalid), 64'h2);
      applyStimulus(2'b00, 7'd1, 7'd2, 1'b0, 1'b1, 64'h0);
      checkOutput("t3_rdv1", 64'(src_readdatavalid), 64'h2);
      applyStimulus(2'b00, 7'd1, 7'd2, 1'b0, 1'b0, 64'h0);
      checkOutput("t3_out_drained", 64'(outstanding), 64'h0);

      // Fill the routing FIFO with zero-length (treated as single-beat) bursts from requester 0
      src_address = {48'h3000, 48'h4000};
      for (int k = 0; k < MAX_OUT; k++) begin
         applyStimulus(2'b01, 7'd0, 7'd1, 1'b0, 1'b0, 64'h0);
         if (k == 0) checkOutput("t4_bc_zero_fwd", 64'(snk_burstcount), 64'h0);
      end
      applyStimulus(2'b01, 7'd0, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t4_full_out", 64'(outstanding), 64'd16);
      checkOutput("t4_full_snk_read", 64'(snk_read), 64'h0);
      checkOutput("t4_full_waitreq", 64'(src_waitrequest), 64'h3);
      applyStimulus(2'b01, 7'd0, 7'd1, 1'b0, 1'b1, 64'h0);
      checkOutput("t4_pop_no_bypass", 64'(snk_read), 64'h0);
      checkOutput("t4_pop_rdv", 64'(src_readdatavalid), 64'h1);
      applyStimulus(2'b01, 7'd0, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t4_freed_out", 64'(outstanding), 64'd15);
      checkOutput("t4_freed_snk_read", 64'(snk_read), 64'h1);
      checkOutput("t4_freed_waitreq", 64'(src_waitrequest), 64'h2);
      applyStimulus(2'b00, 7'd0, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t4_refull_out", 64'(outstanding), 64'd16);
      for (int k = 0; k < MAX_OUT; k++) begin
         applyStimulus(2'b00, 7'd0, 7'd1, 1'b0, 1'b1, 64'h0);
      end
      applyStimulus(2'b00, 7'd0, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t4_drained_out", 64'(outstanding), 64'h0);
      checkOutput("t4_no_err", 64'(rsp_err), 64'h0);

      // Orphan response beat sets the sticky error
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b1, 64'h0);
      checkOutput("t5_orphan_rdv", 64'(src_readdatavalid), 64'h0);
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t5_err_set", 64'(rsp_err), 64'h1);
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b0, 64'h0);
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t5_err_sticky", 64'(rsp_err), 64'h1);
      pulseReset();
      checkOutput("t5_err_cleared", 64'(rsp_err), 64'h0);
      releaseReset();

      // Perf counters: grants 0,1,0,1,0,1 then 0,0 -> 5 for req0, 3 for req1
      for (int k = 0; k < 6; k++) begin
         applyStimulus(2'b11, 7'd4, 7'd4, 1'b0, 1'b0, 64'h0);
         checkOutput("t6_grant", 64'(src_waitrequest), (k % 2 == 0) ? 64'h2 : 64'h1);
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(2'b01, 7'd4, 7'd4, 1'b0, 1'b0, 64'h0);
      end
      applyStimulus(2'b00, 7'd4, 7'd4, 1'b0, 1'b1, 64'h0);
`ifdef HOST_RD_ARB_PERF_EN
      expPerf = {32'd3, 32'd5};
`else
      expPerf = 64'h0;
`endif
      checkOutput("t6_perf", 64'(perf_cnt), expPerf);
      checkOutput("t6_out", 64'(outstanding), 64'd8);
      checkOutput("t6_first_owner", 64'(src_readdatavalid), 64'h1);

      // Reset in the middle of a burst, then an orphan beat after release
      pulseReset();
      checkOutput("t7_rst_out", 64'(outstanding), 64'h0);
      checkOutput("t7_rst_perf", 64'(perf_cnt), 64'h0);
      releaseReset();
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b1, 64'h0);
      checkOutput("t7_orphan_rdv", 64'(src_readdatavalid), 64'h0);
      applyStimulus(2'b00, 7'd1, 7'd1, 1'b0, 1'b0, 64'h0);
      checkOutput("t7_err", 64'(rsp_err), 64'h1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
